// File: rtl/game_pkg.sv
// Shared types and constants for the Pac-Man game flow controller.
package game_pkg;

  localparam int GRID_X_W = 6;
  localparam int GRID_Y_W = 5;
  localparam int LIVES_W  = 3;

  // Top-level game phases. The encoding is exported on the state port.
  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_RESUME     = 3'd2,
    ST_LEVEL_DONE = 3'd3,
    ST_OVER       = 3'd4
  } game_state_t;

  // Elaboration-time helper for sizing counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_down_counter.sv
// Loadable down counter that saturates at zero. Priority: reset/clear, load, decrement.
module down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load, load beats decrement, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: INIT -> PLAY -> (RESUME | LEVEL_DONE | OVER), with a timed
// frightened mode during which colliding ghosts are eaten instead of pacman.
//
// Strobe semantics: power_pill and level_clear are single-cycle pulses sampled
// on the rising edge and only honoured in PLAY; ghost_eaten is a registered
// pulse that stays high for exactly one cycle per sampled frightened collision.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_GHOSTS   = 2,
  parameter int START_LIVES  = 3,
  parameter int RESUME_DELAY = 250000000,
  parameter int LEVEL_DELAY  = 100000000,
  parameter int FRIGHT_TIME  = 350000000,
  parameter int LEVEL_W      = 4
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic [GRID_X_W-1:0]            pac_x,
  input  logic [GRID_Y_W-1:0]            pac_y,
  input  logic [GRID_X_W*NUM_GHOSTS-1:0] ghost_x,
  input  logic [GRID_Y_W*NUM_GHOSTS-1:0] ghost_y,
  input  logic                           power_pill,
  input  logic                           level_clear,
  output logic [2:0]                     state,
  output logic                           sprite_reset,
  output logic                           map_wr_reset,
  output logic                           score_reset,
  output logic                           ghost_enable,
  output logic                           frightened,
  output logic [NUM_GHOSTS-1:0]          ghost_eaten,
  output logic [LIVES_W-1:0]             lives,
  output logic [LEVEL_W-1:0]             level,
  output logic                           game_over
);

  // Delay counter holds at most max(delay)-1; a floor of 2 keeps it >= 1 bit.
  localparam int DLY_W = $clog2(max_int(max_int(RESUME_DELAY, LEVEL_DELAY), 2));
  localparam int FR_W  = $clog2(FRIGHT_TIME + 1);

  localparam logic [DLY_W-1:0]   RESUME_LOAD = DLY_W'(RESUME_DELAY - 1);
  localparam logic [DLY_W-1:0]   LEVEL_LOAD  = DLY_W'(LEVEL_DELAY - 1);
  localparam logic [FR_W-1:0]    FRIGHT_LOAD = FR_W'(FRIGHT_TIME);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = {LEVEL_W{1'b1}};

  game_state_t           state_q, state_d;
  logic [LIVES_W-1:0]    lives_q, lives_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic [NUM_GHOSTS-1:0] eaten_q, eaten_d;

  logic [NUM_GHOSTS-1:0] hit;
  logic                  fatal;
  logic                  fright_q;
  logic                  dly_zero;

  logic                  dly_load, dly_dec;
  logic [DLY_W-1:0]      dly_val;
  logic [DLY_W-1:0]      dly_cnt;
  logic                  fr_load, fr_clear, fr_dec;
  logic [FR_W-1:0]       fr_cnt;

  // Per-ghost tile compare against pacman's next position.
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
    assign hit[g] = (ghost_x[g*GRID_X_W +: GRID_X_W] == pac_x) &&
                    (ghost_y[g*GRID_Y_W +: GRID_Y_W] == pac_y);
  end

  assign fright_q = (fr_cnt != '0);
  assign dly_zero = (dly_cnt == '0);
  // Judged against last cycle's frightened flag, so a pill on the same edge does not save pacman.
  assign fatal    = (|hit) && !fright_q;

  // Phase transitions, life/level bookkeeping and counter controls.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    level_d  = level_q;
    eaten_d  = '0;
    dly_load = 1'b0;
    dly_val  = RESUME_LOAD;
    dly_dec  = 1'b0;
    fr_load  = 1'b0;
    fr_clear = 1'b1;
    fr_dec   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          level_d = '0;
        end
      end
      ST_PLAY: begin
        fr_clear = 1'b0;
        fr_dec   = 1'b1;
        eaten_d  = fright_q ? hit : '0;
        if (fatal) begin
          fr_clear = 1'b1;
          if (lives_q > LIVES_W'(1)) begin
            lives_d  = lives_q - LIVES_W'(1);
            dly_load = 1'b1;
            dly_val  = RESUME_LOAD;
            state_d  = ST_RESUME;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
          end
        end else if (level_clear) begin
          fr_clear = 1'b1;
          dly_load = 1'b1;
          dly_val  = LEVEL_LOAD;
          state_d  = ST_LEVEL_DONE;
        end else if (power_pill) begin
          fr_load = 1'b1;
        end
      end
      ST_RESUME: begin
        dly_dec = 1'b1;
        if (dly_zero) begin
          state_d = ST_PLAY;
        end
      end
      ST_LEVEL_DONE: begin
        dly_dec = 1'b1;
        if (dly_zero) begin
          state_d = ST_PLAY;
          if (level_q != LEVEL_MAX) begin
            level_d = level_q + LEVEL_W'(1);
          end
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Phase, lives, level and eaten-pulse registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_INIT;
      lives_q <= LIVES_INIT;
      level_q <= '0;
      eaten_q <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      eaten_q <= eaten_d;
    end
  end

  down_counter #(.W(DLY_W)) u_delay_cnt (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .clear_i    (1'b0),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .dec_i      (dly_dec),
    .cnt_o      (dly_cnt)
  );

  down_counter #(.W(FR_W)) u_fright_cnt (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .clear_i    (fr_clear),
    .load_i     (fr_load),
    .load_val_i (FRIGHT_LOAD),
    .dec_i      (fr_dec),
    .cnt_o      (fr_cnt)
  );

  // Moore decode of the strobes driven into the datapath blocks.
  always_comb begin
    sprite_reset = 1'b1;
    map_wr_reset = 1'b1;
    score_reset  = 1'b1;
    ghost_enable = 1'b0;
    game_over    = 1'b0;
    case (state_q)
      ST_PLAY: begin
        sprite_reset = 1'b0;
        map_wr_reset = 1'b0;
        score_reset  = 1'b0;
        ghost_enable = 1'b1;
      end
      ST_RESUME: begin
        map_wr_reset = 1'b0;
        score_reset  = 1'b0;
      end
      ST_LEVEL_DONE: begin
        score_reset = 1'b0;
      end
      ST_OVER: begin
        sprite_reset = 1'b0;
        score_reset  = 1'b0;
        game_over    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state       = state_q;
  assign frightened  = fright_q;
  assign ghost_eaten = eaten_q;
  assign lives       = lives_q;
  assign level       = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios followed by random play,
// checked cycle by cycle against a timestamp-based reference model.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int NG = 3;
  localparam int SL = 3;
  localparam int RD = 4;
  localparam int LD = 3;
  localparam int FT = 8;
  localparam int LW = 2;
  localparam int W  = 17;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, power_pill, level_clear;
  logic [5:0]        pac_x;
  logic [4:0]        pac_y;
  logic [6*NG-1:0]   ghost_x;
  logic [5*NG-1:0]   ghost_y;
  logic [2:0]        state;
  logic              sprite_reset, map_wr_reset, score_reset, ghost_enable;
  logic              frightened, game_over;
  logic [NG-1:0]     ghost_eaten;
  logic [2:0]        lives;
  logic [LW-1:0]     level;

  game_flow_ctrl #(
    .NUM_GHOSTS(NG), .START_LIVES(SL), .RESUME_DELAY(RD),
    .LEVEL_DELAY(LD), .FRIGHT_TIME(FT), .LEVEL_W(LW)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .power_pill(power_pill), .level_clear(level_clear),
    .state(state), .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
    .score_reset(score_reset), .ghost_enable(ghost_enable),
    .frightened(frightened), .ghost_eaten(ghost_eaten),
    .lives(lives), .level(level), .game_over(game_over)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: phases end at absolute edge numbers rather than counting down.
  int          edge_k   = 0;
  game_state_t m_mode   = ST_INIT;
  int          m_lives  = SL;
  int          m_level  = 0;
  int          m_fr_end = 0;   // frightened while edge index < m_fr_end
  int          m_end    = 0;   // edge at which RESUME / LEVEL_DONE returns to PLAY
  logic [NG-1:0] m_eaten = '0;

  function automatic logic [W-1:0] expected_vec();
    logic [3:0] strobes;  // sprite, map, score, ghost_enable
    logic       fr;
    case (m_mode)
      ST_INIT:       strobes = 4'b1110;
      ST_PLAY:       strobes = 4'b0001;
      ST_RESUME:     strobes = 4'b1000;
      ST_LEVEL_DONE: strobes = 4'b1100;
      default:       strobes = 4'b0100;
    endcase
    fr = (m_mode == ST_PLAY) && (edge_k < m_fr_end);
    return {3'(m_mode), strobes, fr, m_eaten, 3'(m_lives), LW'(m_level),
            (m_mode == ST_OVER)};
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit pill,
                            input bit clr, input logic [NG-1:0] hit);
    bit fr_prev;
    edge_k++;
    fr_prev = (edge_k - 1) < m_fr_end;
    m_eaten = '0;
    if (rst) begin
      m_mode = ST_INIT; m_lives = SL; m_level = 0; m_fr_end = 0;
    end else begin
      case (m_mode)
        ST_INIT: begin
          m_fr_end = 0;
          if (st) begin m_mode = ST_PLAY; m_lives = SL; m_level = 0; end
        end
        ST_PLAY: begin
          if (fr_prev) m_eaten = hit;
          if (hit != '0 && !fr_prev) begin
            m_fr_end = 0;
            if (m_lives > 1) begin
              m_lives--; m_mode = ST_RESUME; m_end = edge_k + RD;
            end else begin
              m_lives = 0; m_mode = ST_OVER;
            end
          end else if (clr) begin
            m_fr_end = 0; m_mode = ST_LEVEL_DONE; m_end = edge_k + LD;
          end else if (pill) begin
            m_fr_end = edge_k + FT;
          end
        end
        ST_RESUME: if (edge_k == m_end) m_mode = ST_PLAY;
        ST_LEVEL_DONE: begin
          if (edge_k == m_end) begin
            m_mode = ST_PLAY;
            if (m_level < (1 << LW) - 1) m_level++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Driver: one clock of stimulus; ghosts in mask sit on pacman's tile.
  task automatic cycle(input bit rst, input bit st, input bit pill,
                       input bit clr, input logic [NG-1:0] mask);
    logic [NG-1:0] hit;
    int px, py, gx, gy;
    @(negedge clk);
    px = $urandom_range(0, 39);
    py = $urandom_range(0, 29);
    for (int i = 0; i < NG; i++) begin
      if (mask[i]) begin
        gx = px; gy = py;
      end else if ($urandom_range(0, 1) == 1) begin
        gx = px; gy = (py + 1 + i) % 30;
      end else begin
        gx = (px + 1 + i) % 40; gy = $urandom_range(0, 29);
      end
      ghost_x[6*i +: 6] = 6'(gx);
      ghost_y[5*i +: 5] = 5'(gy);
      hit[i] = (gx == px) && (gy == py);
    end
    reset = rst; start = st; power_pill = pill; level_clear = clr;
    pac_x = 6'(px); pac_y = 5'(py);
    model_step(rst, st, pill, clr, hit);
    exp_q.push_back(expected_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0);
  endtask

  // Monitor: the DUT presents a full output vector after every edge.
  initial begin
    logic [W-1:0] got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {state, sprite_reset, map_wr_reset, score_reset, ghost_enable,
               frightened, ghost_eaten, lives, level, game_over};
        checks++;
        if (got === e) passed++;
        else $display("FAIL outputs edge=%0d got=%h exp=%h", edge_k, got, e);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; power_pill = 1'b0; level_clear = 1'b0;
    pac_x = '0; pac_y = '0; ghost_x = '1; ghost_y = '1;

    // Start
    cycle(1, 0, 0, 0, '0); cycle(1, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, '0); idle(2);
    // Fatal hits: single ghost, then all three overlapping
    cycle(0, 0, 0, 0, 3'b010); idle(6);
    cycle(0, 0, 0, 0, 3'b111); idle(6);
    // Power pill, eat ghost2, re-pill, then expire
    cycle(0, 0, 1, 0, '0); idle(2);
    cycle(0, 0, 0, 0, 3'b100); idle(2);
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 0, 0, 3'b011); idle(9);
    // Pill and hit on the same edge: fatal, last life -> OVER
    cycle(0, 0, 1, 0, 3'b001); idle(1);
    for (int i = 0; i < 4; i++) cycle(0, i[0], 1, 1, '0);
    cycle(1, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, '0); idle(1);
    // Level clear, then clear racing a fatal hit
    cycle(0, 0, 0, 1, '0); idle(4);
    cycle(0, 0, 0, 1, 3'b001); idle(5);
    // Level saturation
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 0, 1, '0); idle(4); end
    // Reset mid-RESUME while frightened had been armed
    cycle(0, 0, 1, 0, '0); cycle(0, 0, 0, 0, 3'b000);
    cycle(0, 0, 0, 0, '0);
    idle(7);
    cycle(0, 0, 0, 0, 3'b100); idle(1);
    cycle(1, 0, 0, 0, '0); idle(2);
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, 3'b010); idle(5);

    // Random play
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
            ($urandom_range(0, 9) == 0) ? NG'($urandom_range(1, 7)) : '0);
    end

    @(posedge clk); #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain left=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised top-level game sequencer for the Pac-Man datapath. It replaces the inline init/game/resume/over controller and supports NUM_GHOSTS ghosts, configurable lives and delays, and a timed frightened (power-pill) mode in which ghosts can be eaten. It adds a level-complete phase with a level counter. It drives the reset/enable strobes for the sprite, map-writer and score blocks, and exports lives/level to the HEX displays.

Parameters:
NUM_GHOSTS, 2, number of ghosts checked for collision (1..8)
START_LIVES, 3, lives loaded at reset (1..7)
RESUME_DELAY, 250000000, cycles spent in RESUME after a life is lost (>=1)
LEVEL_DELAY, 100000000, cycles spent in LEVEL_DONE before the next level (>=1)
FRIGHT_TIME, 350000000, cycles frightened mode lasts after a power pill (>=1)
LEVEL_W, 4, level counter width

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high; returns block to INIT
start  in  1  level-sensitive start request (SW)
pac_x  in  6  pacman next grid x (0..39)
pac_y  in  5  pacman next grid y (0..29)
ghost_x  in  6*NUM_GHOSTS  ghost next grid x, ghost i at [6i+:6]
ghost_y  in  5*NUM_GHOSTS  ghost next grid y, ghost i at [5i+:5]
power_pill  in  1  one-cycle pulse: pacman ate a power pill
level_clear  in  1  one-cycle pulse: last dot eaten
state  out  3  current state encoding (package enum)
sprite_reset  out  1  holds pacman/ghost position logic in reset
map_wr_reset  out  1  holds map RAM writer in reset
score_reset  out  1  clears pill counter / keyboard control
ghost_enable  out  1  enables ghost AI stepping
frightened  out  1  frightened mode active
ghost_eaten  out  NUM_GHOSTS  one-cycle pulse per ghost eaten
lives  out  3  remaining lives
level  out  LEVEL_W  current level, 0-based
game_over  out  1  high in OVER

Behaviour:
- States: INIT, PLAY, RESUME, LEVEL_DONE, OVER. All state and counters are registered on the CLOCK_50 rising edge.
- Reset values: state=INIT, lives=START_LIVES, level=0, fright_cnt=0, delay_cnt=0, ghost_eaten=0.
- Collision: hit[i] = (ghost_x[i]==pac_x)&(ghost_y[i]==pac_y). It is combinational and only acted on in PLAY.
- Frightened mode: frightened = (fright_cnt!=0). It is registered, so a collision is judged against frightened as it was before the current edge.
- Outputs are Moore decodes of state:
  - INIT: sprite_reset=1, map_wr_reset=1, score_reset=1, ghost_enable=0.
  - PLAY: all three resets=0, ghost_enable=1.
  - RESUME: sprite_reset=1, map_wr_reset=0, score_reset=0, ghost_enable=0.
  - LEVEL_DONE: sprite_reset=1, map_wr_reset=1, score_reset=0, ghost_enable=0.
  - OVER: sprite_reset=0, map_wr_reset=1, score_reset=0, ghost_enable=0, game_over=1.
- INIT -> PLAY when start=1. lives=START_LIVES and level=0 are reloaded on this edge.
- PLAY, priority highest first:
  1. Fatal hit (|hit & !frightened) with lives>1: lives-1, delay_cnt=RESUME_DELAY-1, fright_cnt=0, go to RESUME.
  2. Fatal hit with lives==1: lives=0, go to OVER.
  3. level_clear: delay_cnt=LEVEL_DELAY-1, fright_cnt=0, go to LEVEL_DONE.
  4. Otherwise stay in PLAY.
- A fatal hit costs exactly one life, even if several ghosts overlap pacman on that cycle.
- Frightened hit (frightened & hit[i]): ghost_eaten[i]=1 for one cycle for every hitting ghost. No life is lost and the state is unchanged.
- Holding collision: if a ghost stays on pacman's tile, ghost_eaten re-pulses every cycle. The ghost AI must relocate the ghost; this block does not mask repeats.
- Power pill in PLAY: fright_cnt=FRIGHT_TIME. A pill arriving while frightened restarts the count to FRIGHT_TIME.
- Otherwise fright_cnt decrements toward 0 and saturates there. fright_cnt is forced to 0 outside PLAY.
- RESUME: delay_cnt decrements; at delay_cnt==0 go to PLAY. The block therefore spends exactly RESUME_DELAY cycles in RESUME.
- LEVEL_DONE: same countdown with LEVEL_DELAY. On exit to PLAY, level increments and saturates at 2^LEVEL_W-1. Lives are unchanged.
- OVER: stays until reset. start is ignored.
- Inputs power_pill and level_clear are ignored outside PLAY.
- reset mid-countdown or mid-frightened: all counters clear at the next edge and the block returns to INIT.
- Counter widths: delay_cnt is $clog2(max(RESUME_DELAY,LEVEL_DELAY)) bits; fright_cnt is $clog2(FRIGHT_TIME+1) bits.

Decomposition:
- Package game_pkg holds:
  - the state enum game_state_t (3-bit);
  - constants GRID_X_W=6, GRID_Y_W=5, LIVES_W=3.
- Sub-module down_counter: loadable, saturating at 0, parametrised width. Instantiated twice, once for delay_cnt and once for fright_cnt.
- The collision compare is a generate loop inside this block.

Test Plan:
(Parameters for all scenarios: NUM_GHOSTS=3, RESUME_DELAY=4, LEVEL_DELAY=3, FRIGHT_TIME=8.)
- Start: reset 2 cycles, then start=1 -> state PLAY next edge, lives=3, ghost_enable=1, all resets=0.
- Fatal hit: ghost1 at (5,7) = pacman -> lives 3->2, state RESUME for exactly 4 cycles, then PLAY. With ghosts 0 and 2 also overlapping, lives still drops by 1 only.
- Power pill and eating:
  - power_pill pulse -> frightened=1 for 8 cycles.
  - Hit on ghost2 at cycle 3 -> ghost_eaten=3'b100 for one cycle, lives unchanged.
  - Second pill at cycle 6 -> frightened stays high 8 more cycles.
  - Hit on the same cycle as the pill edge (frightened previously 0) -> treated as fatal.
- Game over: three fatal hits -> lives 0, state OVER, game_over=1, map_wr_reset=1. start toggling has no effect; reset -> INIT, lives=3.
- Level clear:
  - level_clear pulse -> LEVEL_DONE for 3 cycles with map_wr_reset=1, then PLAY with level=1.
  - level_clear on the same cycle as a fatal hit -> RESUME wins, level unchanged.
- Level saturation and mid-operation reset:
  - With LEVEL_W=2, 4 clears -> level saturates at 3.
  - reset asserted mid-RESUME -> INIT next edge, delay_cnt=0, fright_cnt=0.
